// File: rtl/c1_src_buf_ctrl.sv
// c1_src_buf_ctrl
// Sequencer for the C1 five-bank source buffer (five identical copies of the
// input image). A frame runs in two phases:
//   LOAD - IMG_W*IMG_H pixels are written through the shared write port.
//   SCAN - the five read ports are driven so that every issued cycle returns
//          one column k of a 5x5 window; bank p supplies window row p.
//
// Optional feature: define C1_SRC_CTRL_PERF_EN to add the 32-bit stall_cnt
// output (SCAN cycles with dn_ready low, cleared on an accepted start).
//
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   start                 frame start pulse, sampled in IDLE only
//   pix_in, pix_valid     input pixel stream; pix_ready is high in LOAD
//   wr_data, wr_addr, we  buffer write port (one cycle behind acceptance)
//   rd_addr_5P            five read addresses, port p at [ADDR_W*(p+1)-1:ADDR_W*p]
//   dn_ready              MAC array can take a tap next cycle
//   tap_valid, tap_col,   tap qualifiers, aligned with the RAM read data
//   tap_last, frame_last
//   out_row, out_col      output coordinate of the current window
//   busy, done            state != IDLE; one-cycle end-of-frame pulse
`timescale 1ns/1ps

module c1_src_buf_ctrl #(
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_W-1:0]     pix_in,
    input  logic                  pix_valid,
    output logic                  pix_ready,
    output logic [DATA_W-1:0]     wr_data,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic                  we,
    output logic [5*ADDR_W-1:0]   rd_addr_5P,
    input  logic                  dn_ready,
    output logic                  tap_valid,
    output logic [2:0]            tap_col,
    output logic                  tap_last,
    output logic                  frame_last,
    output logic [7:0]            out_row,
    output logic [7:0]            out_col,
    output logic                  busy,
    output logic                  done
`ifdef C1_SRC_CTRL_PERF_EN
    ,
    output logic [31:0]           stall_cnt
`endif
);

    localparam int K  = 5;
    localparam int OW = IMG_W - K + 1;
    localparam int OH = IMG_H - K + 1;

    localparam logic [ADDR_W-1:0] NPIX_LAST = ADDR_W'(IMG_W * IMG_H - 1);
    // Base address steps: (c,4)->(c+1,0) moves back K-2 words,
    // (r,OW-1,4)->(r+1,0,0) moves forward IMG_W-OW-K+2 words.
    localparam logic [ADDR_W-1:0] COL_BACK  = ADDR_W'(K - 2);
    localparam logic [ADDR_W-1:0] ROW_FWD   = ADDR_W'(IMG_W - OW - K + 2);
    localparam logic [7:0]        OW_LAST   = 8'(OW - 1);
    localparam logic [7:0]        OH_LAST   = 8'(OH - 1);
    localparam logic [2:0]        K_LAST    = 3'(K - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SCAN, DONE} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   wr_cnt;
    logic [7:0]          r_cnt, c_cnt;
    logic [2:0]          k_cnt;
    logic [ADDR_W-1:0]   base_addr;   // r*IMG_W + c + k, tracked without a multiplier

    logic accept, load_last, issue, scan_last, start_ok;

    assign start_ok  = (state == IDLE) && start;
    assign accept    = (state == LOAD) && pix_valid;
    assign load_last = accept && (wr_cnt == NPIX_LAST);
    assign issue     = (state == SCAN) && dn_ready;
    assign scan_last = issue && (r_cnt == OH_LAST) && (c_cnt == OW_LAST) && (k_cnt == K_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pix_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = LOAD;
            LOAD: begin
                pix_ready = 1'b1;
                if (load_last) state_nxt = SCAN;
            end
            SCAN: if (scan_last) state_nxt = DONE;
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        busy = (state != IDLE);
    end

    // Counters: write index and (r, c, k) scan position
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt    <= '0;
            r_cnt     <= '0;
            c_cnt     <= '0;
            k_cnt     <= '0;
            base_addr <= '0;
        end else if (start_ok) begin
            wr_cnt    <= '0;
            r_cnt     <= '0;
            c_cnt     <= '0;
            k_cnt     <= '0;
            base_addr <= '0;
        end else begin
            if (accept) wr_cnt <= wr_cnt + 1'b1;
            if (issue) begin
                if (k_cnt == K_LAST) begin
                    k_cnt <= '0;
                    if (c_cnt == OW_LAST) begin
                        c_cnt     <= '0;
                        r_cnt     <= r_cnt + 1'b1;
                        base_addr <= base_addr + ROW_FWD;
                    end else begin
                        c_cnt     <= c_cnt + 1'b1;
                        base_addr <= base_addr - COL_BACK;
                    end
                end else begin
                    k_cnt     <= k_cnt + 1'b1;
                    base_addr <= base_addr + 1'b1;
                end
            end
        end
    end

    // Stage p1: registered write port and read-issue outputs
    logic                 we_p1;
    logic [DATA_W-1:0]    wr_data_p1;
    logic [ADDR_W-1:0]    wr_addr_p1;
    logic [5*ADDR_W-1:0]  rd_addr_p1;
    logic                 vld_p1;
    logic [2:0]           tap_col_p1;
    logic                 tap_last_p1;
    logic                 frame_last_p1;
    logic [7:0]           out_row_p1, out_col_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_p1         <= 1'b0;
            wr_data_p1    <= '0;
            wr_addr_p1    <= '0;
            rd_addr_p1    <= '0;
            vld_p1        <= 1'b0;
            tap_col_p1    <= '0;
            tap_last_p1   <= 1'b0;
            frame_last_p1 <= 1'b0;
            out_row_p1    <= '0;
            out_col_p1    <= '0;
        end else begin
            we_p1         <= accept;
            vld_p1        <= issue;
            tap_last_p1   <= issue && (k_cnt == K_LAST);
            frame_last_p1 <= scan_last;
            if (accept) begin
                wr_data_p1 <= pix_in;
                wr_addr_p1 <= wr_cnt;
            end
            if (issue) begin
                for (int p = 0; p < K; p++)
                    rd_addr_p1[p*ADDR_W +: ADDR_W] <= base_addr + ADDR_W'(p * IMG_W);
                tap_col_p1 <= k_cnt;
                out_row_p1 <= r_cnt;
                out_col_p1 <= c_cnt;
            end
        end
    end

    assign we         = we_p1;
    assign wr_data    = wr_data_p1;
    assign wr_addr    = wr_addr_p1;
    assign rd_addr_5P = rd_addr_p1;
    assign tap_valid  = vld_p1;
    assign tap_col    = tap_col_p1;
    assign tap_last   = tap_last_p1;
    assign frame_last = frame_last_p1;
    assign out_row    = out_row_p1;
    assign out_col    = out_col_p1;

`ifdef C1_SRC_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                           stall_cnt <= '0;
        else if (start_ok)                    stall_cnt <= '0;
        else if ((state == SCAN) && !dn_ready) stall_cnt <= stall_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_c1_src_buf_ctrl.sv
`timescale 1ns/1ps

module tb_c1_src_buf_ctrl;

    localparam int IMG_W  = 32;
    localparam int IMG_H  = 32;
    localparam int ADDR_W = 32;
    localparam int K      = 5;
    localparam int OW     = IMG_W - K + 1;
    localparam int OH     = IMG_H - K + 1;
    localparam int NPIX   = IMG_W * IMG_H;
    localparam int NTAP   = OW * OH * K;

    logic                 clk;
    logic                 rst_n;
    logic                 start;
    logic [15:0]          pix_in;
    logic                 pix_valid;
    logic                 pix_ready;
    logic [15:0]          wr_data;
    logic [ADDR_W-1:0]    wr_addr;
    logic                 we;
    logic [5*ADDR_W-1:0]  rd_addr_5P;
    logic                 dn_ready;
    logic                 tap_valid;
    logic [2:0]           tap_col;
    logic                 tap_last;
    logic                 frame_last;
    logic [7:0]           out_row;
    logic [7:0]           out_col;
    logic                 busy;
    logic                 done;
`ifdef C1_SRC_CTRL_PERF_EN
    logic [31:0]          stall_cnt;
`endif

    c1_src_buf_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .DATA_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .wr_data    (wr_data),
        .wr_addr    (wr_addr),
        .we         (we),
        .rd_addr_5P (rd_addr_5P),
        .dn_ready   (dn_ready),
        .tap_valid  (tap_valid),
        .tap_col    (tap_col),
        .tap_last   (tap_last),
        .frame_last (frame_last),
        .out_row    (out_row),
        .out_col    (out_col),
        .busy       (busy),
        .done       (done)
`ifdef C1_SRC_CTRL_PERF_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { int a; int d; } wr_t;
    typedef struct { int r; int c; int k; } tap_t;

    wr_t  wr_q[$];
    tap_t tap_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    bit   exp_tv   = 1'b0;
    bit   exp_done = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: samples on the falling edge, pops on each presented output.
    wr_t  mw;
    tap_t mt;
    always @(negedge clk) begin
        if (rst_n) begin
            check("tap_valid_timing", tap_valid, exp_tv);
            check("done_timing", done, exp_done);
            if (we) begin
                if (wr_q.size() == 0) check("we_unexpected", we, 0);
                else begin
                    mw = wr_q.pop_front();
                    check("wr_addr", wr_addr, mw.a);
                    check("wr_data", wr_data, mw.d);
                end
            end
            if (tap_valid) begin
                if (tap_q.size() == 0) check("tap_unexpected", tap_valid, 0);
                else begin
                    mt = tap_q.pop_front();
                    for (int p = 0; p < K; p++)
                        check("rd_addr", rd_addr_5P[p*ADDR_W +: ADDR_W],
                              (mt.r + p) * IMG_W + mt.c + mt.k);
                    check("tap_col", tap_col, mt.k);
                    check("tap_last", tap_last, mt.k == K - 1);
                    check("frame_last", frame_last,
                          (mt.r == OH - 1) && (mt.c == OW - 1) && (mt.k == K - 1));
                    check("out_row", out_row, mt.r);
                    check("out_col", out_col, mt.c);
                end
            end
        end
    end

    task automatic tick(input bit tv, input bit dn);
        @(posedge clk);
        #1;
        exp_tv   = tv;
        exp_done = dn;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"}, we, 0);
        check({tag, "_wr_addr"}, wr_addr, 0);
        check({tag, "_wr_data"}, wr_data, 0);
        check({tag, "_rd_addr_zero"}, rd_addr_5P == '0, 1);
        check({tag, "_tap_valid"}, tap_valid, 0);
        check({tag, "_tap_col"}, tap_col, 0);
        check({tag, "_tap_last"}, tap_last, 0);
        check({tag, "_frame_last"}, frame_last, 0);
        check({tag, "_out_row"}, out_row, 0);
        check({tag, "_out_col"}, out_col, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pix_ready"}, pix_ready, 0);
`ifdef C1_SRC_CTRL_PERF_EN
        check({tag, "_stall_cnt"}, stall_cnt, 0);
`endif
    endtask

    // One frame driven against a cycle-level model of the sequencer.
    // pix_mode: 0 continuous/index data, 1 every other cycle, 2 random.
    // dn_mode : 0 always ready, 1 three-cycle stall mid-row, 2 random.
    task automatic run_frame(input int pix_mode, input int dn_mode,
                             input bit extra_start, input int abort_at);
        int   i, issues, stalls, cyc, st3;
        bit   pv, dn;
        logic [15:0] val;
        wr_t  w;
        tap_t t;
        i = 0; issues = 0; stalls = 0; cyc = 0; st3 = 0;
        pix_valid = 1'b1;           // ignored while IDLE
        pix_in    = 16'hDEAD;
        start     = 1'b1;
        tick(0, 0);
        start = 1'b0;
        check("busy_load", busy, 1);
        check("pix_ready_load", pix_ready, 1);
        while (i < NPIX) begin
            case (pix_mode)
                0:       pv = 1'b1;
                1:       pv = (cyc % 2 == 0);
                default: pv = ($urandom_range(0, 2) != 0);
            endcase
            val       = (pix_mode == 0) ? 16'(i) : 16'($urandom);
            pix_valid = pv;
            pix_in    = val;
            start     = extra_start && (cyc == 7);
            if (pv) begin
                w.a = i; w.d = int'(val);
                wr_q.push_back(w);
                i++;
            end
            cyc++;
            tick(0, 0);
        end
        start = 1'b0;
        check("busy_scan", busy, 1);
        check("pix_ready_scan", pix_ready, 0);
        while (issues < NTAP) begin
            if (issues == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_all_zero("midreset");
                wr_q.delete();
                tap_q.delete();
                exp_tv = 1'b0; exp_done = 1'b0;
                start = 1'b0; pix_valid = 1'b0; dn_ready = 1'b1;
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                tick(0, 0);
                tick(0, 0);
                check("busy_after_reset", busy, 0);
                return;
            end
            case (dn_mode)
                0: dn = 1'b1;
                1: begin
                    if (issues == 60 && st3 < 3) begin dn = 1'b0; st3++; end
                    else dn = 1'b1;
                end
                default: dn = ($urandom_range(0, 3) != 0);
            endcase
            dn_ready  = dn;
            pix_valid = 1'($urandom_range(0, 1));
            pix_in    = 16'($urandom);
            start     = extra_start && (issues == 100);
            if (dn) begin
                t.r = issues / (K * OW);
                t.c = (issues / K) % OW;
                t.k = issues % K;
                tap_q.push_back(t);
                issues++;
            end else stalls++;
            tick(dn, dn && (issues == NTAP));
        end
        start = 1'b0; pix_valid = 1'b0; dn_ready = 1'b1;
        tick(0, 0);
        check("busy_idle", busy, 0);
        check("wr_q_drained", wr_q.size(), 0);
        check("tap_q_drained", tap_q.size(), 0);
`ifdef C1_SRC_CTRL_PERF_EN
        check("stall_cnt", stall_cnt, stalls);
        tick(0, 0);
        check("stall_cnt_hold", stall_cnt, stalls);
`endif
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; pix_valid = 1'b0; pix_in = '0; dn_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        tick(0, 0);
        check("idle_busy", busy, 0);
        run_frame(0, 0, 1'b0, -1);
        run_frame(1, 1, 1'b1, -1);
        run_frame(2, 2, 1'b0, -1);
        run_frame(0, 2, 1'b0, 700);
        run_frame(2, 0, 1'b0, -1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
